// File: rtl/dl_sequencer_pkg.sv
// dl_sequencer_pkg
// Shared definitions for the download sequencer: FSM state encoding,
// one-hot target codes and the file-index to target decode.
package dl_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] TGT_NONE   = 3'b000;
  localparam logic [2:0] TGT_BIOS   = 3'b001;
  localparam logic [2:0] TGT_SPRITE = 3'b010;
  localparam logic [2:0] TGT_MUSIC  = 3'b100;

  // Index 0 and 1 both load the BIOS region; unknown indices map to no target.
  function automatic logic [2:0] decode_target(input logic [7:0] idx);
    case (idx)
      8'd0, 8'd1: return TGT_BIOS;
      8'd3:       return TGT_SPRITE;
      8'd4:       return TGT_MUSIC;
      default:    return TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// dl_fifo
// Synchronous show-ahead FIFO: o_data always presents the oldest entry.
// A push while full is accepted only when a pop happens on the same edge.
// Ports:
//   clk_sys, reset_n     clock, async active-low reset (empties the FIFO)
//   i_push, i_data       write strobe and data
//   i_pop                remove head (ignored when empty)
//   o_data               head entry (undefined when empty)
//   o_full, o_empty      occupancy flags
//   o_count              occupancy, 0..DEPTH
module dl_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/dl_sequencer.sv
// dl_sequencer
// Routes an hps_io byte download to one of three write targets through a
// small buffer, holding the core in reset while the BIOS is reloaded.
// Optional feature: define DL_SEQUENCER_CHECKSUM_EN to accumulate a 16-bit
// sum of delivered bytes on dl_sum (otherwise dl_sum is tied to 0).
// Ports:
//   clk_sys, reset_n                 clock, async active-low reset
//   ioctl_download/wr/addr/dout/index  hps_io download interface
//   ioctl_wait                       backpressure to hps_io
//   tgt_req/addr/data, tgt_ack       per-target write handshake
//   core_reset                       system reset hold during BIOS load
//   dl_done, dl_error, dl_count, dl_sum  download status
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for ioctl_download; status outputs held
// ST_LOAD  | accepting bytes into the buffer
// ST_DRAIN | download closed, emptying buffer to the target
// ST_DONE  | one-cycle completion, dl_done high
module dl_sequencer
  import dl_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [2:0]        tgt_req,
  output logic [ADDR_W-1:0] tgt_addr,
  output logic [7:0]        tgt_data,
  input  logic [2:0]        tgt_ack,
  output logic              core_reset,
  output logic              dl_done,
  output logic              dl_error,
  output logic [24:0]       dl_count,
  output logic [15:0]       dl_sum
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_target;
  logic [24:0]         r_count;
  logic                r_error;
  logic                r_wait;

  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CW-1:0]       w_fifo_count;
  logic [ADDR_W+7:0]   w_head;
  logic [2:0]          w_tgt_req;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_start;
  logic                w_wr_load;
  logic                w_addr_ok;
  logic [CW-1:0]       w_occ_nxt;
  logic                w_wait_nxt;

  assign w_tgt_req = w_fifo_empty ? TGT_NONE : r_target;
  assign w_pop     = |(w_tgt_req & tgt_ack);
  assign w_addr_ok = ((ioctl_addr >> ADDR_W) == 25'd0);
  assign w_start   = (r_state == ST_IDLE) && ioctl_download;
  assign w_wr_load = (r_state == ST_LOAD) && ioctl_wr;
  // A pop on the same edge frees the slot, so a full buffer can still take the byte.
  assign w_push    = w_wr_load && (r_target != TGT_NONE) && w_addr_ok &&
                     (!w_fifo_full || w_pop);
  assign w_drop    = w_wr_load && !w_push;

  dl_fifo #(
    .W     (ADDR_W + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (ioctl_download) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (!ioctl_download) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_fifo_empty && (w_tgt_req == TGT_NONE)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Wait is raised one entry early: hps_io may still issue one more write
  // in the cycle after it sees ioctl_wait.
  assign w_occ_nxt  = w_fifo_count + CW'(w_push) - CW'(w_pop);
  assign w_wait_nxt = (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_DONE) ||
                      (w_occ_nxt >= CW'(FIFO_DEPTH - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_target <= TGT_NONE;
      r_count  <= '0;
      r_error  <= 1'b0;
      r_wait   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_start) begin
        r_target <= decode_target(ioctl_index);
        r_count  <= '0;
        r_error  <= 1'b0;
      end else begin
        if (w_pop)  r_count <= r_count + 25'd1;
        if (w_drop) r_error <= 1'b1;
      end
    end
  end

`ifdef DL_SEQUENCER_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)   r_sum <= '0;
    else if (w_start) r_sum <= '0;
    else if (w_pop) r_sum <= r_sum + {8'd0, w_head[7:0]};
  end

  assign dl_sum = r_sum;
`else
  assign dl_sum = 16'd0;
`endif

  assign ioctl_wait = r_wait;
  assign tgt_req    = w_tgt_req;
  // Head is masked while empty so the outputs read 0 out of reset.
  assign tgt_addr   = w_fifo_empty ? '0 : w_head[ADDR_W+7:8];
  assign tgt_data   = w_fifo_empty ? '0 : w_head[7:0];
  assign core_reset = (r_state != ST_IDLE) && (r_target == TGT_BIOS);
  assign dl_done    = (r_state == ST_DONE);
  assign dl_error   = r_error;
  assign dl_count   = r_count;

endmodule
